// File: rtl/adder_input_ctrl.sv
// Button/switch front end for the adder: sync, debounce, operand capture
// and a one-cycle start handshake that holds operands until done.
module adder_input_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    input  logic             done,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             start,
    output logic             busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // bit 0 = LoadB, bit 1 = Run
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    lvl_q, lvl_d;
    logic [1:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;

    // Two-stage synchroniser for the raw buttons
    always_comb begin
        sync1_d = {Run, LoadB};
        sync2_d = sync1_q;
    end

    // Debounce: level follows the synced value after a stable run;
    // a falling debounced level produces a one-cycle press event
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            lvl_d[i] = lvl_q[i];
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = lvl_q & ~lvl_d;
    end

    // Conditioning registers; released buttons read as 1 after reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            lvl_q   <= 2'b11;
            press_q <= 2'b00;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: Run press starts an op, HOLD waits for Run release
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (press_q[1]) state_d = START;
            START: state_d = WAIT;
            WAIT:  if (done) state_d = HOLD;
            HOLD:  if (lvl_q[1]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values: operands load only in IDLE, strobes follow state
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == IDLE) begin
            if (press_q[0]) b_d = SW;
            if (press_q[1]) a_d = SW;
        end
        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
    end

    // Registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign A_out = a_q;
    assign B_out = b_q;
    assign start = start_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_adder_input_ctrl.sv
// Directed bench for adder_input_ctrl with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adder_input_ctrl;

    logic        Clk;
    logic        Reset;
    logic        LoadB;
    logic        Run;
    logic [15:0] SW;
    logic        done;
    logic [15:0] A_out;
    logic [15:0] B_out;
    logic        start;
    logic        busy;

    int n_vec;
    int n_bad;
    int n_start;
    int base;

    adder_input_ctrl #(
        .WIDTH(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .LoadB(LoadB),
        .Run(Run),
        .SW(SW),
        .done(done),
        .A_out(A_out),
        .B_out(B_out),
        .start(start),
        .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // count every cycle in which start is high
    always @(posedge Clk) begin
        if (start === 1'b1) n_start = n_start + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (start !== 1'b1 && k < 30) begin
            @(negedge Clk);
            k++;
        end
        check(tag, {31'd0, start}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        wait_n(1);
        done = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        n_start = 0;
        Reset   = 1'b0;
        LoadB   = 1'b1;
        Run     = 1'b1;
        SW      = 16'h0000;
        done    = 1'b0;
        wait_n(3);
        check("rst_a", 32'(A_out), 32'h0);
        check("rst_b", 32'(B_out), 32'h0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        Reset = 1'b1;
        wait_n(3);

        // LoadB press captures SW into B only
        SW    = 16'h0002;
        LoadB = 1'b0;
        wait_n(5);
        check("lb_early", 32'(B_out), 32'h0);
        wait_n(3);
        check("lb_b", 32'(B_out), 32'h0002);
        check("lb_a", 32'(A_out), 32'h0);
        wait_n(2);
        LoadB = 1'b1;
        wait_n(12);
        check("lb_nostart", 32'(n_start), 32'd0);
        check("lb_busy", {31'd0, busy}, 32'd0);

        // Run press with done three cycles after start
        SW   = 16'h0001;
        base = n_start;
        Run  = 1'b0;
        wait_start("run_start");
        check("run_a", 32'(A_out), 32'h0001);
        wait_n(1);
        check("run_start_1cyc", {31'd0, start}, 32'd0);
        wait_n(2);
        pulse_done();
        wait_n(4);
        check("run_hold_busy", {31'd0, busy}, 32'd1);
        Run = 1'b1;
        wait_n(4);
        check("run_rel_busy", {31'd0, busy}, 32'd1);
        wait_n(8);
        check("run_idle", {31'd0, busy}, 32'd0);
        check("run_npulse", 32'(n_start - base), 32'd1);

        // short LoadB glitch is filtered
        SW    = 16'h0055;
        LoadB = 1'b0;
        wait_n(2);
        LoadB = 1'b1;
        wait_n(12);
        check("glitch_b", 32'(B_out), 32'h0002);

        // Run held 50 cycles yields exactly one op
        SW   = 16'h0007;
        base = n_start;
        Run  = 1'b0;
        wait_start("hold50_start");
        wait_n(2);
        pulse_done();
        wait_n(40);
        check("hold50_npulse", 32'(n_start - base), 32'd1);
        check("hold50_a", 32'(A_out), 32'h0007);
        Run = 1'b1;
        wait_n(12);
        check("hold50_idle", {31'd0, busy}, 32'd0);

        // LoadB press while waiting on the adder is dropped
        SW  = 16'h0003;
        Run = 1'b0;
        wait_start("wait_start");
        SW    = 16'hFFFF;
        LoadB = 1'b0;
        wait_n(10);
        LoadB = 1'b1;
        wait_n(12);
        check("wait_b", 32'(B_out), 32'h0002);
        check("wait_busy", {31'd0, busy}, 32'd1);
        pulse_done();
        wait_n(2);
        check("wait_hold", {31'd0, busy}, 32'd1);
        check("wait_a", 32'(A_out), 32'h0003);
        Run = 1'b1;
        wait_n(12);
        check("wait_idle", {31'd0, busy}, 32'd0);
        LoadB = 1'b0;
        wait_n(10);
        LoadB = 1'b1;
        wait_n(12);
        check("after_b", 32'(B_out), 32'hFFFF);

        // simultaneous LoadB and Run
        SW    = 16'h00AA;
        base  = n_start;
        LoadB = 1'b0;
        Run   = 1'b0;
        wait_start("both_start");
        check("both_a", 32'(A_out), 32'h00AA);
        check("both_b", 32'(B_out), 32'h00AA);
        wait_n(2);
        pulse_done();
        LoadB = 1'b1;
        Run   = 1'b1;
        wait_n(12);
        check("both_npulse", 32'(n_start - base), 32'd1);
        check("both_idle", {31'd0, busy}, 32'd0);

        // reset in WAIT abandons the op
        SW  = 16'h1234;
        Run = 1'b0;
        wait_start("rst_op_start");
        check("rst_op_a", 32'(A_out), 32'h1234);
        wait_n(2);
        Reset = 1'b0;
        #1;
        check("midrst_a", 32'(A_out), 32'h0);
        check("midrst_b", 32'(B_out), 32'h0);
        check("midrst_start", {31'd0, start}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        Run = 1'b1;
        wait_n(2);
        Reset = 1'b1;
        base  = n_start;
        wait_n(20);
        check("midrst_nostart", 32'(n_start - base), 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
